mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of data words and of every address.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low, sampled on rising edge of clk.
REQ-004 ireq  input  1  instruction port request; read-only.
REQ-005 iaddr  input  DATA_W  instruction port address.
REQ-006 iack  output  1  one-cycle pulse; irdata valid in this cycle.
REQ-007 irdata  output  DATA_W  instruction read data.
REQ-008 dreq  input  1  data port request.
REQ-009 dwe  input  1  data port write enable, qualified by dreq.
REQ-010 daddr  input  DATA_W  data port address.
REQ-011 dwdata  input  DATA_W  data port write data.
REQ-012 dack  output  1  one-cycle pulse; data access complete, drdata valid for reads.
REQ-013 drdata  output  DATA_W  data read data.
REQ-014 maddr  output  DATA_W  shared memory address, registered.
REQ-015 mwdata  output  DATA_W  shared memory write data, registered.
REQ-016 mwe  output  1  shared memory write strobe, registered; memory writes on the rising edge ending the cycle.
REQ-017 mrdata  input  DATA_W  shared memory read data, combinational from maddr.

Function
REQ-018 FSM states: IDLE, GNT_I, GNT_D; exactly one state active.
REQ-019 Arbitration is evaluated in IDLE, GNT_I and GNT_D. Eligible requesters: ireq (masked in GNT_I) and dreq (masked in GNT_D).
REQ-020 One eligible requester: next state is its GNT state. Both eligible: selection per REQ-031/REQ-032. None: next state IDLE.
REQ-021 On a grant edge, maddr/mwdata/mwe load from the winner: I -> iaddr, mwe=0; D -> daddr, dwdata, mwe=dwe.
REQ-022 With no grant, mwe loads 0; maddr and mwdata hold.
REQ-023 In GNT_I: iack=1, irdata=mrdata. In GNT_D: dack=1, drdata=mrdata. Outside their state, acks=0 and rdata=0.
REQ-024 Latency: request first seen in IDLE -> ack in the next cycle; at most one access per cycle; back-to-back alternation GNT_D->GNT_I->GNT_D when both keep requesting.
REQ-025 Requesters hold req, addr and data stable until their ack. Req deasserted before ack: the pending request is dropped without error.
REQ-026 A requester keeping req high in its ack cycle is masked for that arbitration and is not granted twice in a row while the other port is requesting.
REQ-027 Sole requester with req held continuously: granted every other cycle (GNT_x -> IDLE -> GNT_x).
REQ-028 No combinational path from mrdata to mwe/maddr; mrdata reaches irdata/drdata only.

Reset
REQ-029 rst_n=0 at an edge: state=IDLE, maddr=0, mwdata=0, mwe=0, round-robin pointer=D-preferred; hence iack=dack=0, irdata=drdata=0 the following cycle.
REQ-030 Reset in a GNT cycle aborts the ack for later cycles. The memory still commits the write at that edge if mwe was already 1; the arbiter does not retract it.

Configuration
REQ-031 Macro ARB_RR_EN defined: round-robin. On a tie the port not granted most recently wins; the pointer updates on every grant.
REQ-032 ARB_RR_EN undefined: fixed priority, D always wins ties. No pointer register exists. I may starve under continuous dreq; this is accepted.

Verification
REQ-033 Reset then ireq=1, iaddr=0x0010, mrdata model mem[0x10]=0x1234 -> iack one cycle later, irdata=0x1234, mwe=0 throughout.
REQ-034 dreq=1, dwe=1, daddr=0x0020, dwdata=0xBEEF, then a read of 0x0020 -> mwe=1 exactly one cycle, then drdata=0xBEEF.
REQ-035 ireq and dreq both asserted together from IDLE and held -> GNT_D, GNT_I, GNT_D... in both configurations. ARB_RR_EN: after last grant I, tie -> D; after last grant D, tie -> I.
REQ-036 dreq held high 6 cycles, ireq=0 -> dack pattern 1,0,1,0,1,0; no duplicate write in consecutive cycles.
REQ-037 rst_n=0 during GNT_D write to 0x0030 -> memory holds the write, dack=0 and state IDLE next cycle; pending ireq is granted only after rst_n=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction read / data read-write) arbiter onto one shared memory.
// Define ARB_RR_EN for round-robin tie-breaking; the default build uses fixed D priority.
module mem_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ireq,
  input  logic [DATA_W-1:0] iaddr,
  output logic              iack,
  output logic [DATA_W-1:0] irdata,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic              dack,
  output logic [DATA_W-1:0] drdata,
  output logic [DATA_W-1:0] maddr,
  output logic [DATA_W-1:0] mwdata,
  output logic              mwe,
  input  logic [DATA_W-1:0] mrdata
);

  // state | meaning
  // IDLE  | no access this cycle
  // GNT_I | instruction read on the memory, iack high
  // GNT_D | data read or write on the memory, dack high
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       elig_i;
  logic       elig_d;
  logic       gnt_i;
  logic       gnt_d;

  // the port being served this cycle may not win the next slot
  assign elig_i = ireq && (state != GNT_I);
  assign elig_d = dreq && (state != GNT_D);

`ifdef ARB_RR_EN
  logic last_d;

  // ties go to whichever port was not granted most recently
  assign gnt_d = elig_d && (!elig_i || !last_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (gnt_i || gnt_d) begin
      last_d <= gnt_d;
    end
  end
`else
  assign gnt_d = elig_d;
`endif

  assign gnt_i = elig_i && !gnt_d;

  always_comb begin
    state_nxt = IDLE;
    if (gnt_d) begin
      state_nxt = GNT_D;
    end else if (gnt_i) begin
      state_nxt = GNT_I;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // memory-side registers depend only on requests, never on mrdata
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      maddr  <= '0;
      mwdata <= '0;
      mwe    <= 1'b0;
    end else if (gnt_d) begin
      maddr  <= daddr;
      mwdata <= dwdata;
      mwe    <= dwe;
    end else if (gnt_i) begin
      maddr  <= iaddr;
      mwe    <= 1'b0;
    end else begin
      mwe    <= 1'b0;
    end
  end

  assign iack   = (state == GNT_I);
  assign dack   = (state == GNT_D);
  assign irdata = iack ? mrdata : '0;
  assign drdata = dack ? mrdata : '0;

endmodule
